// File: rtl/macguffin_round_engine.sv
// macguffin_round_engine: iterative MacGuffin Feistel round datapath, one round per clock
module macguffin_round_engine #(
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic        in_decrypt,
  output logic [4:0]  rk_idx,
  input  logic [47:0] rk,
  output logic [47:0] sbox_in,
  input  logic [15:0] sbox_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block
);
  localparam int EXP_SEL [8][6] = '{
    '{2, 5, 6, 9, 11, 13}, '{1, 4, 7, 10, 8, 14}, '{3, 6, 8, 13, 0, 15}, '{12, 14, 1, 2, 4, 10},
    '{0, 10, 3, 14, 6, 12}, '{7, 8, 12, 15, 1, 5}, '{9, 15, 5, 11, 2, 7}, '{11, 13, 0, 4, 3, 9}
  };
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [63:0] blk;
  logic dec;
  logic [4:0] cnt;
  logic [2:0][15:0] fw;
  logic [47:0] ex;
  assign fw = dec ? {blk[31:16], blk[47:32], blk[63:48]} : {blk[15:0], blk[31:16], blk[47:32]};
  for (genvar k = 0; k < 8; k++) begin : g_exp
    for (genvar j = 0; j < 6; j++) begin : g_bit
      assign ex[6*k+j] = fw[j/2][EXP_SEL[k][j]];
    end
  end
  assign sbox_in = ex ^ rk;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign out_block = out_valid ? blk : '0;
  assign rk_idx = state == RUN ? (dec ? 5'(ROUNDS - 1) - cnt : cnt) : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? RUN : IDLE;
      RUN: state_nx = cnt == 5'(ROUNDS - 1) ? DONE : RUN;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      blk <= '0;
      dec <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      blk <= in_block;
      dec <= in_decrypt;
      cnt <= '0;
    end else if (state == RUN) begin
      blk <= dec ? {blk[15:0] ^ sbox_out, blk[63:16]} : {blk[47:0], blk[63:48] ^ sbox_out};
      cnt <= cnt + 5'd1;
    end
  end
endmodule

// File: tb/tb_macguffin_round_engine.sv
// tb_macguffin_round_engine: directed and random checks of the round engine against a word-level model
module tb_macguffin_round_engine;
  localparam int R = 32;
  localparam int EXP_SEL [8][6] = '{
    '{2, 5, 6, 9, 11, 13}, '{1, 4, 7, 10, 8, 14}, '{3, 6, 8, 13, 0, 15}, '{12, 14, 1, 2, 4, 10},
    '{0, 10, 3, 14, 6, 12}, '{7, 8, 12, 15, 1, 5}, '{9, 15, 5, 11, 2, 7}, '{11, 13, 0, 4, 3, 9}
  };
  logic clk = 0, rst = 1, in_valid = 0, in_decrypt = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [63:0] in_block = '0, out_block;
  logic [4:0] rk_idx;
  logic [47:0] rk, sbox_in;
  logic [15:0] sbox_out;
  logic [47:0] key_ram [R];
  int mode = 0;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  macguffin_round_engine #(.ROUNDS(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .in_decrypt(in_decrypt), .rk_idx(rk_idx), .rk(rk), .sbox_in(sbox_in), .sbox_out(sbox_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
  );
  function automatic logic [15:0] bank(input logic [47:0] x);
    logic [15:0] o;
    logic [5:0] v;
    o = '0;
    for (int k = 0; k < 8; k++) begin
      v = x[6*k +: 6];
      o[2*k +: 2] = 2'((((v * 7) ^ (v >> 3) ^ (k * 5)) >> 1) & 3);
    end
    return o;
  endfunction
  function automatic logic [15:0] sbox(input logic [47:0] x);
    return mode == 0 ? 16'h0000 : mode == 1 ? 16'hFFFF : bank(x);
  endfunction
  assign rk = key_ram[rk_idx];
  assign sbox_out = sbox(sbox_in);
  function automatic logic [47:0] expand(input logic [15:0] p, q, r);
    logic [47:0] e;
    logic [15:0] src;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 6; j++) begin
        src = j < 2 ? p : j < 4 ? q : r;
        e[6*k+j] = src[EXP_SEL[k][j]];
      end
    return e;
  endfunction
  function automatic logic [63:0] model(input logic [63:0] b, input logic d);
    logic [15:0] w [4];
    logic [15:0] t;
    logic [47:0] key;
    for (int i = 0; i < 4; i++) w[i] = b[63-16*i -: 16];
    for (int r = 0; r < R; r++) begin
      key = key_ram[d ? R - 1 - r : r];
      if (!d) begin
        t = w[0] ^ sbox(expand(w[1], w[2], w[3]) ^ key);
        w[0] = w[1]; w[1] = w[2]; w[2] = w[3]; w[3] = t;
      end else begin
        t = w[3] ^ sbox(expand(w[0], w[1], w[2]) ^ key);
        w[3] = w[2]; w[2] = w[1]; w[1] = w[0]; w[0] = t;
      end
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [63:0] b, input logic d);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1; in_block = b; in_decrypt = d;
    @(negedge clk);
    in_valid = 0; in_block = $urandom; in_decrypt = ~d;
  endtask
  task automatic rounds(input logic d, input bit trace);
    for (int r = 0; r < R; r++) begin
      if (trace) begin
        chk("rk_idx", 64'(rk_idx), 64'(d ? R - 1 - r : r));
        chk("busy_no_ready", 64'(in_ready), 64'd0);
        chk("busy_no_valid", 64'(out_valid), 64'd0);
      end
      @(negedge clk);
    end
  endtask
  task automatic finish(input string tag, input logic [63:0] exp, output logic [63:0] res);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk(tag, out_block, exp);
    res = out_block;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask
  task automatic run(input string tag, input logic [63:0] b, input logic d, input logic [63:0] exp,
                     input bit trace, output logic [63:0] res);
    start(b, d);
    rounds(d, trace);
    finish(tag, exp, res);
  endtask
  initial begin
    logic [63:0] res, ct, pt, exp;
    for (int i = 0; i < R; i++) key_ram[i] = {16'($urandom), 32'($urandom)};
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_block", out_block, 64'd0);
    chk("rst_rk_idx", 64'(rk_idx), 64'd0);
    mode = 0;
    run("zero_enc", 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF, 1, res);
    mode = 1;
    run("ones_enc", 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF, 0, res);
    run("ones_dec", 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF, 1, res);
    mode = 2;
    run("zero_blk_enc", 64'd0, 0, model(64'd0, 0), 0, ct);
    run("zero_blk_dec", ct, 1, 64'd0, 0, res);
    exp = model(64'hDEAD_BEEF_0BAD_F00D, 0);
    start(64'hDEAD_BEEF_0BAD_F00D, 0);
    rounds(0, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); in_block = {$urandom, $urandom}; in_decrypt = 1'($urandom);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_block", out_block, exp);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 0;
    finish("stall_out", exp, res);
    start(64'h1111_2222_3333_4444, 0);
    repeat (12) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_block", out_block, 64'd0);
    chk("abort_rk_idx", 64'(rk_idx), 64'd0);
    run("after_abort", 64'h1111_2222_3333_4444, 0, model(64'h1111_2222_3333_4444, 0), 1, res);
    for (int n = 0; n < 150; n++) begin
      pt = {$urandom, $urandom};
      run("rand_enc", pt, 0, model(pt, 0), 0, ct);
      run("rand_dec", ct, 1, pt, 0, res);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
